// File: rtl/vgroup_wb_collector_if.sv
// Issue/writeback/status bundle between the vector pipeline and the group collector.
interface vgroup_wb_collector_if #(
  parameter int NREGS = 32
);
  localparam int RW = $clog2(NREGS);

  logic             issue_valid;
  logic [RW-1:0]    issue_rdest;
  logic [3:0]       issue_lmul;
  logic             issue_ready;
  logic             wb_valid;
  logic [RW-1:0]    wb_rdest;
  logic [NREGS-1:0] busy_mask;
  logic [3:0]       pending_cnt;
  logic             group_done;
  logic [RW-1:0]    group_rdest;
  logic             wb_err;

  modport master (
    output issue_valid, issue_rdest, issue_lmul, wb_valid, wb_rdest,
    input  issue_ready, busy_mask, pending_cnt, group_done, group_rdest, wb_err
  );

  modport slave (
    input  issue_valid, issue_rdest, issue_lmul, wb_valid, wb_rdest,
    output issue_ready, busy_mask, pending_cnt, group_done, group_rdest, wb_err
  );
endinterface

// File: rtl/vgroup_wb_collector.sv
// Tracks one LMUL register group at writeback: busy marking, in-order
// writeback checking and a completion pulse for the hazard logic.
//
//   state   | meaning
//   IDLE    | no group open, new issue may be accepted
//   COLLECT | group open, waiting for its writebacks in register order
module vgroup_wb_collector #(
  parameter int MAX_LMUL = 8,
  parameter int NREGS    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  vgroup_wb_collector_if.slave  bus
);
  localparam int RW = $clog2(NREGS);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t           state_q, state_n;
  logic [RW-1:0]    base_q, base_n;
  logic [3:0]       lmul_q, lmul_n;
  logic [3:0]       idx_q, idx_n;
  logic [NREGS-1:0] busy_q, busy_n;
  logic [3:0]       pending_q, pending_n;
  logic             done_q, done_n;
  logic [RW-1:0]    grd_q, grd_n;
  logic             err_q, err_n;

  logic             lmul_legal;
  logic [RW-1:0]    expect_reg;

  // Register indices wrap modulo NREGS through the natural RW-bit add.
  function automatic logic [NREGS-1:0] group_mask(input logic [RW-1:0] b,
                                                  input logic [3:0]    n);
    logic [NREGS-1:0] m;
    logic [RW-1:0]    r;
    m = '0;
    for (int i = 0; i < MAX_LMUL; i++) begin
      r = b + RW'(i);
      if (4'(i) < n) m[r] = 1'b1;
    end
    return m;
  endfunction

  assign lmul_legal = ((bus.issue_lmul == 4'd1) || (bus.issue_lmul == 4'd2) ||
                       (bus.issue_lmul == 4'd4) || (bus.issue_lmul == 4'd8)) &&
                      (int'(bus.issue_lmul) <= MAX_LMUL);

  assign expect_reg = base_q + RW'(idx_q);

  assign bus.issue_ready = (state_q == IDLE) && !reset;
  assign bus.busy_mask   = busy_q;
  assign bus.pending_cnt = pending_q;
  assign bus.group_done  = done_q;
  assign bus.group_rdest = grd_q;
  assign bus.wb_err      = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      lmul_q    <= '0;
      idx_q     <= '0;
      busy_q    <= '0;
      pending_q <= '0;
      done_q    <= 1'b0;
      grd_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      base_q    <= base_n;
      lmul_q    <= lmul_n;
      idx_q     <= idx_n;
      busy_q    <= busy_n;
      pending_q <= pending_n;
      done_q    <= done_n;
      grd_q     <= grd_n;
      err_q     <= err_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    base_n    = base_q;
    lmul_n    = lmul_q;
    idx_n     = idx_q;
    busy_n    = busy_q;
    pending_n = pending_q;
    done_n    = 1'b0;
    grd_n     = grd_q;
    err_n     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A writeback alongside an issue is never counted toward the new group.
        if (bus.wb_valid) err_n = 1'b1;
        if (bus.issue_valid) begin
          if (lmul_legal) begin
            base_n    = bus.issue_rdest;
            lmul_n    = bus.issue_lmul;
            idx_n     = '0;
            busy_n    = group_mask(bus.issue_rdest, bus.issue_lmul);
            pending_n = bus.issue_lmul;
            state_n   = COLLECT;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (bus.wb_valid) begin
          if (bus.wb_rdest == expect_reg) begin
            busy_n[expect_reg] = 1'b0;
            idx_n              = idx_q + 4'd1;
            pending_n          = pending_q - 4'd1;
            if (idx_q == lmul_q - 4'd1) begin
              done_n  = 1'b1;
              grd_n   = base_q;
              state_n = IDLE;
            end
          end else begin
            err_n = 1'b1;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_vgroup_wb_collector.sv
// Directed vector table plus a held-issue sequence for vgroup_wb_collector.
module tb_vgroup_wb_collector;
  logic clk;
  logic reset;

  vgroup_wb_collector_if bus();

  vgroup_wb_collector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [4:0]  ir;
    logic [3:0]  il;
    logic        wv;
    logic [4:0]  wr;
    logic [31:0] busy;
    logic [3:0]  pend;
    logic        done;
    logic [4:0]  grd;
    logic        err;
    logic        rdy;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic rst, input logic iv, input logic [4:0] ir,
                     input logic [3:0] il, input logic wv, input logic [4:0] wr,
                     input logic [31:0] busy, input logic [3:0] pend,
                     input logic done, input logic [4:0] grd,
                     input logic err, input logic rdy);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ir = ir; v.il = il; v.wv = wv; v.wr = wr;
    v.busy = busy; v.pend = pend; v.done = done; v.grd = grd;
    v.err = err; v.rdy = rdy;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [4:0] ir,
                       input logic [3:0] il, input logic wv, input logic [4:0] wr);
    @(negedge clk);
    reset           = rst;
    bus.issue_valid = iv;
    bus.issue_rdest = ir;
    bus.issue_lmul  = il;
    bus.wb_valid    = wv;
    bus.wb_rdest    = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] busy,
                           input logic [3:0] pend, input logic done,
                           input logic [4:0] grd, input logic err,
                           input logic rdy);
    chk({tag, " busy_mask"},   bus.busy_mask,   busy);
    chk({tag, " pending_cnt"}, 32'(bus.pending_cnt), 32'(pend));
    chk({tag, " group_done"},  32'(bus.group_done),  32'(done));
    chk({tag, " group_rdest"}, 32'(bus.group_rdest), 32'(grd));
    chk({tag, " wb_err"},      32'(bus.wb_err),      32'(err));
    chk({tag, " issue_ready"}, 32'(bus.issue_ready), 32'(rdy));
  endtask

  initial begin
    bit seen;
    reset           = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_rdest = '0;
    bus.issue_lmul  = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_rdest    = '0;

    //  rst iv ir   il wv wr     busy          pend done grd err rdy
    add(1, 0, 0,  0, 0, 0,  32'h0000_0000, 0, 0, 0,  0, 0);
    // basic group 8..11
    add(0, 1, 8,  4, 0, 0,  32'h0000_0F00, 4, 0, 0,  0, 0);
    add(0, 0, 0,  0, 1, 8,  32'h0000_0E00, 3, 0, 0,  0, 0);
    add(0, 0, 0,  0, 1, 9,  32'h0000_0C00, 2, 0, 0,  0, 0);
    add(0, 0, 0,  0, 1, 10, 32'h0000_0800, 1, 0, 0,  0, 0);
    add(0, 0, 0,  0, 1, 11, 32'h0000_0000, 0, 1, 8,  0, 1);
    add(0, 0, 0,  0, 0, 0,  32'h0000_0000, 0, 0, 8,  0, 1);
    // wrap-around 30,31,0,1
    add(0, 1, 30, 4, 0, 0,  32'hC000_0003, 4, 0, 8,  0, 0);
    add(0, 0, 0,  0, 1, 30, 32'h8000_0003, 3, 0, 8,  0, 0);
    add(0, 0, 0,  0, 1, 31, 32'h0000_0003, 2, 0, 8,  0, 0);
    add(0, 0, 0,  0, 1, 0,  32'h0000_0002, 1, 0, 8,  0, 0);
    add(0, 0, 0,  0, 1, 1,  32'h0000_0000, 0, 1, 30, 0, 1);
    // out-of-order writeback
    add(0, 1, 4,  2, 0, 0,  32'h0000_0030, 2, 0, 30, 0, 0);
    add(0, 0, 0,  0, 1, 5,  32'h0000_0030, 2, 0, 30, 1, 0);
    add(0, 0, 0,  0, 1, 4,  32'h0000_0020, 1, 0, 30, 0, 0);
    add(0, 0, 0,  0, 1, 5,  32'h0000_0000, 0, 1, 4,  0, 1);
    // illegal issue, idle writeback
    add(0, 1, 10, 3, 0, 0,  32'h0000_0000, 0, 0, 4,  1, 1);
    add(0, 0, 0,  0, 1, 7,  32'h0000_0000, 0, 0, 4,  1, 1);
    add(0, 1, 12, 0, 0, 0,  32'h0000_0000, 0, 0, 4,  1, 1);
    // LMUL=8, issue during COLLECT ignored, wrong writeback, reset mid-group
    add(0, 1, 0,  8, 0, 0,  32'h0000_00FF, 8, 0, 4,  0, 0);
    add(0, 1, 20, 2, 0, 0,  32'h0000_00FF, 8, 0, 4,  0, 0);
    add(0, 0, 0,  0, 1, 1,  32'h0000_00FF, 8, 0, 4,  1, 0);
    add(1, 0, 0,  0, 0, 0,  32'h0000_0000, 0, 0, 0,  0, 0);
    add(0, 0, 0,  0, 0, 0,  32'h0000_0000, 0, 0, 0,  0, 1);
    // reset after two of four writebacks
    add(0, 1, 16, 4, 0, 0,  32'h000F_0000, 4, 0, 0,  0, 0);
    add(0, 0, 0,  0, 1, 16, 32'h000E_0000, 3, 0, 0,  0, 0);
    add(0, 0, 0,  0, 1, 17, 32'h000C_0000, 2, 0, 0,  0, 0);
    add(1, 0, 0,  0, 0, 0,  32'h0000_0000, 0, 0, 0,  0, 0);
    add(0, 0, 0,  0, 0, 0,  32'h0000_0000, 0, 0, 0,  0, 1);
    // LMUL=1 back-to-back, new issue in the done cycle
    add(0, 1, 2,  1, 0, 0,  32'h0000_0004, 1, 0, 0,  0, 0);
    add(0, 0, 0,  0, 1, 2,  32'h0000_0000, 0, 1, 2,  0, 1);
    add(0, 1, 3,  1, 0, 0,  32'h0000_0008, 1, 0, 2,  0, 0);
    add(0, 0, 0,  0, 1, 3,  32'h0000_0000, 0, 1, 3,  0, 1);
    // issue + matching writeback together in IDLE: error, not counted
    add(0, 1, 6,  2, 1, 6,  32'h0000_00C0, 2, 0, 3,  1, 0);
    add(0, 0, 0,  0, 1, 6,  32'h0000_0080, 1, 0, 3,  0, 0);
    add(0, 0, 0,  0, 1, 7,  32'h0000_0000, 0, 1, 6,  0, 1);
    // gap cycles inside a group
    add(0, 1, 9,  2, 0, 0,  32'h0000_0600, 2, 0, 6,  0, 0);
    add(0, 0, 0,  0, 0, 0,  32'h0000_0600, 2, 0, 6,  0, 0);
    add(0, 0, 0,  0, 0, 0,  32'h0000_0600, 2, 0, 6,  0, 0);
    add(0, 0, 0,  0, 1, 9,  32'h0000_0400, 1, 0, 6,  0, 0);
    add(0, 0, 0,  0, 1, 10, 32'h0000_0000, 0, 1, 9,  0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].ir, tbl[i].il, tbl[i].wv, tbl[i].wr);
      check_all($sformatf("vec%0d", i), tbl[i].busy, tbl[i].pend, tbl[i].done,
                tbl[i].grd, tbl[i].err, tbl[i].rdy);
    end

    // Upstream holds the next issue through a group; accepted in the done cycle.
    drive(0, 1, 24, 2, 0, 0);
    check_all("hold0", 32'h0300_0000, 2, 0, 9, 0, 0);
    drive(0, 1, 26, 1, 1, 24);
    check_all("hold1", 32'h0200_0000, 1, 0, 9, 0, 0);
    drive(0, 1, 26, 1, 1, 25);
    check_all("hold2", 32'h0000_0000, 0, 1, 24, 0, 1);
    drive(0, 1, 26, 1, 0, 0);
    check_all("hold3", 32'h0400_0000, 1, 0, 24, 0, 0);

    // Bounded wait for completion after a delayed writeback.
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 26);
    seen = bus.group_done;
    for (int c = 0; c < 8 && !seen; c++) begin
      drive(0, 0, 0, 0, 0, 0);
      seen = bus.group_done;
    end
    chk("late_done seen", 32'(seen), 32'd1);
    chk("late_done rdest", 32'(bus.group_rdest), 32'd26);
    chk("late_done busy", bus.busy_mask, 32'h0);

    drive(0, 0, 0, 0, 0, 0);
    check_all("final", 32'h0, 0, 0, 26, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
